// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared RISC-V datapath.
// The master side is the controller; the slave side is the datapath and memory port.
interface multicycle_ctrl_if;
  // instruction fields and status coming back from the datapath / memory
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  // control lines driven by the controller
  logic       mem_req;
  logic       mem_we;
  logic       addr_src;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] imm_control;
  logic       reg_write;
  logic [1:0] result_src;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_control, imm_control,
           reg_write, result_src, illegal
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_control, imm_control,
           reg_write, result_src, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a shared 32-bit RISC-V datapath.
// One ALU and one memory port are time-shared across fetch, address
// generation, branch compare and writeback. Outputs are decoded from the
// state register and the instruction fields held in the instruction register.
module multicycle_ctrl #(
  parameter int DIV_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_ALU    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_WB_MEM    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_LUI       = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_DIV = 3'b100;
  localparam logic [2:0] ALU_REM = 3'b101;

  // counter reload value: EXEC_R occupies DIV_LATENCY cycles for div/rem
  localparam logic [3:0] DIV_LOAD = 4'(DIV_LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] div_cnt_q, div_cnt_d;

  logic       r_legal_s;
  logic       r_long_s;
  logic [2:0] r_alu_s;
  logic       i_legal_s;
  logic [2:0] i_alu_s;
  logic [2:0] dec_imm_s;

  // R-type funct7/funct3 decode: legality, ALU operation, multi-cycle flag
  always_comb begin
    r_legal_s = 1'b0;
    r_long_s  = 1'b0;
    r_alu_s   = ALU_ADD;
    case (bus.funct7)
      7'b0000000: begin
        case (bus.funct3)
          3'b000:  begin r_legal_s = 1'b1; r_alu_s = ALU_ADD; end
          3'b111:  begin r_legal_s = 1'b1; r_alu_s = ALU_AND; end
          3'b010:  begin r_legal_s = 1'b1; r_alu_s = ALU_SLT; end
          default: begin r_legal_s = 1'b0; r_alu_s = ALU_ADD; end
        endcase
      end
      7'b0100000: begin
        if (bus.funct3 == 3'b000) begin
          r_legal_s = 1'b1;
          r_alu_s   = ALU_SUB;
        end else begin
          r_legal_s = 1'b0;
          r_alu_s   = ALU_ADD;
        end
      end
      7'b0000001: begin
        case (bus.funct3)
          3'b100:  begin r_legal_s = 1'b1; r_long_s = 1'b1; r_alu_s = ALU_DIV; end
          3'b110:  begin r_legal_s = 1'b1; r_long_s = 1'b1; r_alu_s = ALU_REM; end
          default: begin r_legal_s = 1'b0; r_long_s = 1'b0; r_alu_s = ALU_ADD; end
        endcase
      end
      default: begin
        r_legal_s = 1'b0;
        r_long_s  = 1'b0;
        r_alu_s   = ALU_ADD;
      end
    endcase
  end

  // I-type ALU funct3 decode and opcode-to-immediate-format decode
  always_comb begin
    i_legal_s = 1'b0;
    i_alu_s   = ALU_ADD;
    case (bus.funct3)
      3'b000:  begin i_legal_s = 1'b1; i_alu_s = ALU_ADD; end
      3'b111:  begin i_legal_s = 1'b1; i_alu_s = ALU_AND; end
      3'b010:  begin i_legal_s = 1'b1; i_alu_s = ALU_SLT; end
      default: begin i_legal_s = 1'b0; i_alu_s = ALU_ADD; end
    endcase
    case (bus.opcode)
      OP_I, OP_LOAD: dec_imm_s = 3'b001;
      OP_STORE:      dec_imm_s = 3'b010;
      OP_BR:         dec_imm_s = 3'b011;
      OP_LUI:        dec_imm_s = 3'b100;
      OP_JAL:        dec_imm_s = 3'b101;
      default:       dec_imm_s = 3'b000;
    endcase
  end

  // state and div counter registers; reset parks the FSM in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // next-state logic and Moore output decode; anything not set stays 0
  always_comb begin
    state_d         = state_q;
    div_cnt_d       = div_cnt_q;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.addr_src    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 2'b00;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = ALU_ADD;
    bus.imm_control = 3'b000;
    bus.reg_write   = 1'b0;
    bus.result_src  = 2'b00;
    bus.illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b10;
        // IR and PC load only on the cycle memory completes the fetch
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // old PC + imm precomputes the branch/jal target into ALUOut
        bus.alu_src_a   = 2'b01;
        bus.alu_src_b   = 2'b01;
        bus.imm_control = dec_imm_s;
        case (bus.opcode)
          OP_R: begin
            state_d   = S_EXEC_R;
            div_cnt_d = DIV_LOAD;
          end
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = r_alu_s;
        if (!r_legal_s) begin
          state_d = S_TRAP;
        end else if (r_long_s && (div_cnt_q != 4'd0)) begin
          div_cnt_d = div_cnt_q - 4'd1;
        end else begin
          state_d = S_WB_ALU;
        end
      end
      S_EXEC_I: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.imm_control = 3'b001;
        bus.alu_control = i_alu_s;
        state_d         = i_legal_s ? S_WB_ALU : S_TRAP;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.imm_control = (bus.opcode == OP_STORE) ? 3'b010 : 3'b001;
        if (bus.funct3 != 3'b010) begin
          state_d = S_TRAP;
        end else if (bus.opcode == OP_STORE) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        bus.mem_req  = 1'b1;
        bus.addr_src = 1'b1;
        state_d      = bus.mem_ready ? S_WB_MEM : S_MEM_READ;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b01;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.addr_src = 1'b1;
        state_d      = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_BRANCH: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = ALU_SUB;
        bus.pc_src      = 2'b01;
        case (bus.funct3)
          3'b000: begin bus.pc_write = bus.zero;  state_d = S_FETCH; end
          3'b001: begin bus.pc_write = ~bus.zero; state_d = S_FETCH; end
          default: begin bus.pc_write = 1'b0;     state_d = S_TRAP;  end
        endcase
      end
      S_JAL: begin
        // rd gets old PC + 4 while the PC takes the target held in ALUOut
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        bus.pc_src    = 2'b01;
        state_d       = S_FETCH;
      end
      S_LUI: begin
        bus.imm_control = 3'b100;
        bus.reg_write   = 1'b1;
        bus.result_src  = 2'b10;
        state_d         = S_FETCH;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
        state_d     = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: every cycle's full output
// vector is compared against hand-built expectations.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.DIV_LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observed outputs packed in the same field order as mk()
  logic [20:0] obs;
  assign obs = {bus.mem_req, bus.mem_we, bus.addr_src, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
                bus.imm_control, bus.reg_write, bus.result_src, bus.illegal};

  function automatic logic [20:0] mk(
    input logic mreq, input logic mwe, input logic asrc, input logic irw, input logic pcw,
    input logic [1:0] pcs, input logic [1:0] sa, input logic [1:0] sb,
    input logic [2:0] ac, input logic [2:0] ic,
    input logic rw, input logic [1:0] rs, input logic ill);
    return {mreq, mwe, asrc, irw, pcw, pcs, sa, sb, ac, ic, rw, rs, ill};
  endfunction

  task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // check the current cycle's outputs, then advance to the next negedge
  task automatic step(input string tag, input logic [20:0] exp);
    #1;
    check_val(tag, obs, exp);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // fetch completing immediately
  task automatic do_fetch();
    bus.mem_ready = 1'b1;
    step("fetch_go", mk(1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b10,3'b000,3'b000,1'b0,2'b00,1'b0));
    bus.mem_ready = 1'b0;
  endtask

  logic [20:0] zero_v;
  logic [20:0] fetch_wait_v;
  logic [20:0] wb_alu_v;

  initial begin
    total = 0;
    bad   = 0;
    zero_v       = '0;
    fetch_wait_v = mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,3'b000,3'b000,1'b0,2'b00,1'b0);
    wb_alu_v     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b1,2'b00,1'b0);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    set_instr(7'h00, 3'b000, 7'h00);

    // reset then one IDLE cycle, then FETCH waiting on memory
    step("reset_outs", zero_v);
    reset = 1'b1;
    step("idle", zero_v);
    step("fetch_wait", fetch_wait_v);

    // add x3,x1,x2 : 0x002081B3
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    do_fetch();
    bus.mem_ready = 1'b1; // ignored outside memory states
    step("add_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b000,1'b0,2'b00,1'b0));
    bus.mem_ready = 1'b0;
    step("add_exec", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b000,3'b000,1'b0,2'b00,1'b0));
    step("add_wb", wb_alu_v);
    step("add_back_fetch", fetch_wait_v);

    // lw x5,8(x1) with three wait cycles in MEM_READ
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    do_fetch();
    step("lw_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b001,1'b0,2'b00,1'b0));
    step("lw_addr", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b001,1'b0,2'b00,1'b0));
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      step("lw_mem_read", mk(1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0,2'b00,1'b0));
    end
    bus.mem_ready = 1'b0;
    step("lw_wb_mem", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b1,2'b01,1'b0));

    // beq taken (zero=1) then not taken (zero=0)
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    for (int k = 0; k < 2; k++) begin
      bus.zero = (k == 0);
      do_fetch();
      step("beq_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b011,1'b0,2'b00,1'b0));
      step(k == 0 ? "beq_taken" : "beq_not_taken",
           mk(1'b0,1'b0,1'b0,1'b0,(k == 0),2'b01,2'b10,2'b00,3'b001,3'b000,1'b0,2'b00,1'b0));
    end
    // bne with zero=0 takes the branch
    set_instr(7'b1100011, 3'b001, 7'b0000000);
    bus.zero = 1'b0;
    do_fetch();
    step("bne_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b011,1'b0,2'b00,1'b0));
    step("bne_taken", mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b10,2'b00,3'b001,3'b000,1'b0,2'b00,1'b0));

    // div x3,x1,x2 : EXEC_R held for exactly 4 cycles
    set_instr(7'b0110011, 3'b100, 7'b0000001);
    do_fetch();
    step("div_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b000,1'b0,2'b00,1'b0));
    for (int i = 0; i < 4; i++)
      step("div_exec", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b100,3'b000,1'b0,2'b00,1'b0));
    step("div_wb", wb_alu_v);

    // jal : reg_write and pc_write together
    set_instr(7'b1101111, 3'b000, 7'b0000000);
    do_fetch();
    step("jal_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b101,1'b0,2'b00,1'b0));
    step("jal", mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b01,2'b10,3'b000,3'b000,1'b1,2'b00,1'b0));

    // lui
    set_instr(7'b0110111, 3'b000, 7'b0000000);
    do_fetch();
    step("lui_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b100,1'b0,2'b00,1'b0));
    step("lui", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b100,1'b1,2'b10,1'b0));

    // sw completing immediately: 4 cycles
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    do_fetch();
    step("sw_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b010,1'b0,2'b00,1'b0));
    step("sw_addr", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b010,1'b0,2'b00,1'b0));
    bus.mem_ready = 1'b1;
    step("sw_mem_write", mk(1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0,2'b00,1'b0));
    bus.mem_ready = 1'b0;
    step("sw_back_fetch", fetch_wait_v);

    // illegal opcode 0x7F: DECODE then TRAP held for 20 cycles
    set_instr(7'h7F, 3'b000, 7'b0000000);
    do_fetch();
    step("trap_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b000,1'b0,2'b00,1'b0));
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      step("trap_hold", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0,2'b00,1'b1));
    bus.mem_ready = 1'b0;

    // leave TRAP via reset, then run a sw into MEM_WRITE and reset mid-request
    reset = 1'b0;
    step("trap_reset", zero_v);
    reset = 1'b1;
    step("idle_after_trap", zero_v);
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    do_fetch();
    step("sw2_decode", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,3'b010,1'b0,2'b00,1'b0));
    step("sw2_addr", mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,3'b010,1'b0,2'b00,1'b0));
    step("sw2_mem_write", mk(1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0,2'b00,1'b0));
    #2;
    check_val("sw2_still_writing", obs,
              mk(1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,3'b000,1'b0,2'b00,1'b0));
    reset = 1'b0;
    #1;
    check_val("async_reset_outs", obs, zero_v);
    @(negedge clk);
    reset = 1'b1;
    step("idle_after_rst", zero_v);
    step("fetch_after_rst", fetch_wait_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
